// File: rtl/ddr3_test_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_test_pkg
//  Description : Shared state encoding, LFSR constants and counter widths for
//                the DDR3 traffic generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package ddr3_test_pkg;

    localparam int          C_STATE_W   = 3;
    localparam logic [2:0]  C_ST_IDLE    = 3'd0;
    localparam logic [2:0]  C_ST_WRITE   = 3'd1;
    localparam logic [2:0]  C_ST_READ    = 3'd2;
    localparam logic [2:0]  C_ST_WAIT_RD = 3'd3;
    localparam logic [2:0]  C_ST_DONE    = 3'd4;

    localparam int          C_ERR_CNT_W = 16;

    // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form taps bits 0,2,3,5
    localparam logic [15:0] C_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] C_LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & C_LFSR_TAPS), s[15:1]};
    endfunction

endpackage : ddr3_test_pkg
`default_nettype wire

// File: rtl/ddr3_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_pattern_gen
//  Description : Test data source; a word counter by default, or a 16-bit
//                PRBS when TRAFFIC_PRBS_PATTERN_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr3_pattern_gen
    import ddr3_test_pkg::*;
#(
    parameter int DQ_BITWIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   advance_i,
    output logic [DQ_BITWIDTH-1:0] pattern_o
);

`ifdef TRAFFIC_PRBS_PATTERN_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = C_LFSR_SEED;
        end else if (advance_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Bit-wise modulo mapping truncates narrow buses and replicates wide ones
    for (genvar i = 0; i < DQ_BITWIDTH; i++) begin : g_bits
        assign pattern_o[i] = lfsr_q[i % 16];
    end
`else
    logic [DQ_BITWIDTH-1:0] count_q;
    logic [DQ_BITWIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (advance_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign pattern_o = count_q;
`endif

endmodule : ddr3_pattern_gen
`default_nettype wire

// File: rtl/ddr3_traffic_generator.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_traffic_generator
//  Description : Writes NUM_WORDS patterned words, reads them back and checks.
//                Optional PRBS data via macro TRAFFIC_PRBS_PATTERN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr3_traffic_generator
    import ddr3_test_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH      = 15,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int DQ_BITWIDTH           = 16,
    parameter int NUM_WORDS             = 256,
    parameter int TIMEOUT_CYCLES        = 4096
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              start,
    input  logic                                              ctrl_ready,
    input  logic [DQ_BITWIDTH-1:0]                            o_user_data,
    input  logic                                              o_user_data_valid,
    output logic                                              write_enable,
    output logic                                              read_enable,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
    output logic [DQ_BITWIDTH-1:0]                            i_user_data,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              pass,
    output logic                                              timeout,
    output logic [C_ERR_CNT_W-1:0]                            error_count,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_fail_address
);

    localparam int              AW    = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
    localparam int              TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW-1:0]   C_LAST_WORD = AW'(NUM_WORDS - 1);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [C_STATE_W-1:0]   state_q, state_d;
    logic [AW-1:0]          cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic                   re_q, re_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   tmo_q, tmo_d;
    logic [C_ERR_CNT_W-1:0] err_q, err_d;
    logic [AW-1:0]          ffa_q, ffa_d;
    logic [TMO_W-1:0]       wait_q, wait_d;

    logic                   gen_load;
    logic                   gen_adv;
    logic [DQ_BITWIDTH-1:0] pattern;

    ddr3_pattern_gen #(
        .DQ_BITWIDTH (DQ_BITWIDTH)
    ) u_pattern_gen (
        .clk       (clk),
        .rst       (reset),
        .load_i    (gen_load),
        .advance_i (gen_adv),
        .pattern_o (pattern)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        re_d     = re_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        ffa_d    = ffa_q;
        wait_d   = wait_q;
        gen_load = 1'b0;
        gen_adv  = 1'b0;

        case (state_q)
            C_ST_IDLE: begin
                if (start) begin
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    tmo_d    = 1'b0;
                    err_d    = '0;
                    ffa_d    = '0;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    we_d     = 1'b1;
                    gen_load = 1'b1;
                    state_d  = C_ST_WRITE;
                end
            end
            C_ST_WRITE: begin
                if (we_q && ctrl_ready) begin
                    if (cnt_q == C_LAST_WORD) begin
                        cnt_d    = '0;
                        we_d     = 1'b0;
                        re_d     = 1'b1;
                        gen_load = 1'b1;
                        state_d  = C_ST_READ;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        gen_adv = 1'b1;
                    end
                end
            end
            C_ST_READ: begin
                if (re_q && ctrl_ready) begin
                    re_d    = 1'b0;
                    wait_d  = '0;
                    state_d = C_ST_WAIT_RD;
                end
            end
            C_ST_WAIT_RD: begin
                if (o_user_data_valid) begin
                    gen_adv = 1'b1;
                    if (o_user_data != pattern) begin
                        if (err_q != {C_ERR_CNT_W{1'b1}}) begin
                            err_d = err_q + 1'b1;
                        end
                        if (err_q == '0) begin
                            ffa_d = cnt_q;
                        end
                    end
                    if (cnt_q == C_LAST_WORD) begin
                        state_d = C_ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        re_d    = 1'b1;
                        state_d = C_ST_READ;
                    end
                end else if (wait_q == C_TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = C_ST_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            C_ST_DONE: begin
                // err_q/tmo_q are final here; start this cycle is deliberately dropped
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_q == '0) && !tmo_q;
                state_d = C_ST_IDLE;
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= C_ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
            err_q   <= '0;
            ffa_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            re_q    <= re_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            ffa_q   <= ffa_d;
            wait_q  <= wait_d;
        end
    end

    assign write_enable        = we_q;
    assign read_enable         = re_q;
    assign i_user_data_address = cnt_q;
    assign i_user_data         = pattern;
    assign busy                = busy_q;
    assign done                = done_q;
    assign pass                = pass_q;
    assign timeout             = tmo_q;
    assign error_count         = err_q;
    assign first_fail_address  = ffa_q;

endmodule : ddr3_traffic_generator
`default_nettype wire

// File: tb/tb_ddr3_traffic_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr3_traffic_generator
//  Description : Directed bench with a memory-model controller for
//                ddr3_traffic_generator (NUM_WORDS=16, TIMEOUT_CYCLES=64).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_traffic_generator;

    localparam int NW  = 16;
    localparam int TMO = 64;
    localparam int AW  = 18;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          ctrl_ready = 1'b0;
    logic [DW-1:0] o_user_data = '0;
    logic          o_user_data_valid = 1'b0;
    logic          write_enable;
    logic          read_enable;
    logic [AW-1:0] i_user_data_address;
    logic [DW-1:0] i_user_data;
    logic          busy;
    logic          done;
    logic          pass;
    logic          timeout;
    logic [15:0]   error_count;
    logic [AW-1:0] first_fail_address;

    always #5 clk = ~clk;

    ddr3_traffic_generator #(
        .ADDRESS_BITWIDTH      (15),
        .BANK_ADDRESS_BITWIDTH (3),
        .DQ_BITWIDTH           (DW),
        .NUM_WORDS             (NW),
        .TIMEOUT_CYCLES        (TMO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .ctrl_ready          (ctrl_ready),
        .o_user_data         (o_user_data),
        .o_user_data_valid   (o_user_data_valid),
        .write_enable        (write_enable),
        .read_enable         (read_enable),
        .i_user_data_address (i_user_data_address),
        .i_user_data         (i_user_data),
        .busy                (busy),
        .done                (done),
        .pass                (pass),
        .timeout             (timeout),
        .error_count         (error_count),
        .first_fail_address  (first_fail_address)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_pat(input int idx);
        logic [15:0] s;
`ifdef TRAFFIC_PRBS_PATTERN_EN
        s = 16'hACE1;
        for (int k = 0; k < idx; k++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
`else
        s = 16'(idx);
`endif
        return s;
    endfunction

    // Model configuration, written by the stimulus process only
    bit m_toggle  = 0;
    bit m_corrupt = 0;
    bit m_drop    = 0;
    int clr_req   = 0;

    // Model state, written by the model process only
    int            clr_ack = 0;
    int            cyc = 0;
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    logic [15:0]   mem [NW];
    bit            pend = 0;
    int            pend_cnt = 0;
    logic [15:0]   pend_data = '0;
    bit            hold_chk = 0;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;
    logic          h_we, h_re;
    int            t_acc3 = -1;
    int            t_tmo = -1;
    bit            tmo_seen = 0;
    logic [15:0]   first_wr = '0;

    // Controller model: decides ready, captures accepts, returns reads 3 cycles later
    always @(negedge clk) begin
        cyc++;
        if (clr_req != clr_ack) begin
            clr_ack  = clr_req;
            wr_cnt   = 0;
            rd_cnt   = 0;
            pend     = 0;
            hold_chk = 0;
            tmo_seen = 0;
            t_acc3   = -1;
            t_tmo    = -1;
        end
        o_user_data_valid = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                o_user_data_valid = 1'b1;
                o_user_data       = pend_data;
                pend              = 0;
            end
        end
        ctrl_ready = m_toggle ? cyc[0] : 1'b1;
        if (hold_chk) begin
            check("hold_addr", 64'(i_user_data_address), 64'(h_addr));
            check("hold_data", 64'(i_user_data), 64'(h_data));
            check("hold_en", {62'd0, write_enable, read_enable}, {62'd0, h_we, h_re});
        end
        hold_chk = (write_enable || read_enable) && !ctrl_ready;
        h_addr = i_user_data_address;
        h_data = i_user_data;
        h_we   = write_enable;
        h_re   = read_enable;
        if (write_enable || read_enable)
            check("excl_enables", 64'(write_enable & read_enable), 64'd0);
        if (write_enable && ctrl_ready) begin
            check("wr_addr", 64'(i_user_data_address), 64'(wr_cnt));
            check("wr_data", 64'(i_user_data), 64'(exp_pat(wr_cnt)));
            if (wr_cnt == 0) first_wr = i_user_data;
            mem[i_user_data_address[3:0]] = i_user_data;
            wr_cnt++;
        end
        if (read_enable && ctrl_ready) begin
            check("rd_addr", 64'(i_user_data_address), 64'(rd_cnt));
            if (m_drop && i_user_data_address == 3) begin
                t_acc3 = cyc;
            end else begin
                pend      = 1;
                pend_cnt  = 3;
                pend_data = mem[i_user_data_address[3:0]] ^
                            {15'd0, m_corrupt && (i_user_data_address == 5 || i_user_data_address == 9)};
            end
            rd_cnt++;
        end
        if (timeout && !tmo_seen) begin
            tmo_seen = 1;
            t_tmo    = cyc;
        end
    end

    typedef struct {
        bit toggle;
        bit corrupt;
        bit drop;
        bit exp_pass;
        int exp_err;
        int exp_ffa;
        bit exp_tmo;
        int exp_wr;
        int exp_rd;
    } vec_t;

    vec_t vecs [4];

    task automatic run_and_wait(input int extra_start_at, output bit ok);
        @(negedge clk); #1;
        clr_req++;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            start = (i == extra_start_at);
            if (done) begin
                ok = 1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},   64'(write_enable), 64'd0);
        check({tag, "_re"},   64'(read_enable), 64'd0);
        check({tag, "_addr"}, 64'(i_user_data_address), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_pass"}, 64'(pass), 64'd0);
        check({tag, "_tmo"},  64'(timeout), 64'd0);
        check({tag, "_err"},  64'(error_count), 64'd0);
        check({tag, "_ffa"},  64'(first_fail_address), 64'd0);
        check({tag, "_data"}, 64'(i_user_data), 64'd0);
    endtask

    initial begin
        bit ok;
        bit found;
        logic [15:0] exp_first;

        vecs[0] = '{0, 0, 0, 1, 0, 0, 0, 16, 16};
        vecs[1] = '{1, 0, 0, 1, 0, 0, 0, 16, 16};
        vecs[2] = '{0, 1, 0, 0, 2, 5, 0, 16, 16};
        vecs[3] = '{0, 0, 1, 0, 0, 0, 1, 16, 4};
`ifdef TRAFFIC_PRBS_PATTERN_EN
        exp_first = 16'hACE1;
`else
        exp_first = 16'h0000;
`endif

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            m_toggle  = vecs[v].toggle;
            m_corrupt = vecs[v].corrupt;
            m_drop    = vecs[v].drop;
            run_and_wait(-1, ok);
            check("done_seen", 64'(ok), 64'd1);
            check("pass",      64'(pass), 64'(vecs[v].exp_pass));
            check("err_count", 64'(error_count), 64'(vecs[v].exp_err));
            check("first_fail", 64'(first_fail_address), 64'(vecs[v].exp_ffa));
            check("timeout",   64'(timeout), 64'(vecs[v].exp_tmo));
            check("busy_end",  64'(busy), 64'd0);
            check("wr_count",  64'(wr_cnt), 64'(vecs[v].exp_wr));
            check("rd_count",  64'(rd_cnt), 64'(vecs[v].exp_rd));
            check("first_wr_data", 64'(first_wr), 64'(exp_first));
            if (vecs[v].drop)
                check("timeout_latency", 64'(t_tmo - t_acc3), 64'd65);
            repeat (4) @(negedge clk);
            #1;
            check("done_held", 64'(done), 64'd1);
            check("pass_held", 64'(pass), 64'(vecs[v].exp_pass));
        end

        // Second start mid-run must not restart the sequence
        m_toggle  = 0;
        m_corrupt = 0;
        m_drop    = 0;
        run_and_wait(20, ok);
        check("busy_start_done", 64'(ok), 64'd1);
        check("busy_start_pass", 64'(pass), 64'd1);
        check("busy_start_wr",   64'(wr_cnt), 64'd16);
        check("busy_start_rd",   64'(rd_cnt), 64'd16);

        // Asynchronous reset while writing word 7
        @(negedge clk); #1;
        clr_req++;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (write_enable && i_user_data_address == 7) begin
                found = 1;
                break;
            end
        end
        check("reach_addr7", 64'(found), 64'd1);
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk); #1;
        reset = 1'b0;
        run_and_wait(-1, ok);
        check("rerun_done", 64'(ok), 64'd1);
        check("rerun_pass", 64'(pass), 64'd1);
        check("rerun_wr",   64'(wr_cnt), 64'd16);
        check("rerun_err",  64'(error_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ddr3_traffic_generator
`default_nettype wire
